// File: rtl/fifo_pkg.sv
// Shared defaults for the single-clock FIFO and its storage.
// The pointer width is derived from the depth.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 1024;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM with one synchronous write port and one registered read port.
// Shaped for block-RAM inference: no reset on the array or the read register.
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    // The FIFO never reads and writes the same address on one edge,
    // so read-during-write behaviour is irrelevant here.
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo.sv
// Synchronous single-clock FIFO: pointers, occupancy count, accept logic and flag decode
// around a block-RAM style storage array.
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);

  localparam int ADDR_WIDTH = addr_width(DEPTH);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // Flags come only from the registered count, so accept has no
  // combinational dependence on the opposite request.
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_DEPTH);
  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_valid_d = rd_valid_q;
    if (wr_accept) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (rd_accept) begin
      rptr_d     = rptr_q + PTR_ONE;
      rd_valid_d = 1'b1;
    end
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wptr_q),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_accept),
    .rd_addr_i (rptr_q),
    .rd_data_o (mem_rd_data)
  );

  // The RAM read register carries no reset; rd_data reads as zero until
  // the first pop after reset.
  assign rd_data = rd_valid_q ? mem_rd_data : '0;

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: a short table of hand-computed vectors, then
// scoreboarded bursts covering order, overflow, underflow, wrap and mid-stream reset.
module tb_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] last_rd = '0;

  fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic          exp_empty;
    logic          exp_full;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model decides acceptance from its
  // pre-edge occupancy, popped words go to the scoreboard.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    bit wa;
    bit ra;
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    wa = w && (model_q.size() < DEPTH);
    ra = r && (model_q.size() > 0);
    @(posedge clk);
    if (ra) sb_q.push_back(model_q.pop_front());
    if (wa) model_q.push_back(d);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (sb_q.size() > 0) begin
      last_rd = sb_q.pop_front();
      check("rd_data", rd_data, last_rd);
    end else begin
      check("rd_hold", rd_data, last_rd);
    end
    check("empty", empty, model_q.size() == 0);
    check("full", full, model_q.size() == DEPTH);
    check("count", dut.count_q, model_q.size());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_empty_now", empty, 1'b1);
    #9;
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_rd_data", rd_data, '0);
    check("rst_count", dut.count_q, '0);
    model_q.delete();
    sb_q.delete();
    last_rd = '0;
    rst = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_BEEF, 1'b0, 1'b0, 32'hA5A5_0001};
    vecs[4] = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0000_BEEF};
    vecs[5] = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0000_BEEF};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0077, 1'b0, 1'b0, 32'h0000_BEEF};
    vecs[7] = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0000_0077};

    do_reset();
    $display("phase: reset done");

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].exp_empty);
      check($sformatf("vec%0d_full", i), full, vecs[i].exp_full);
      check($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
    end
    $display("phase: vector table done");

    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0);
    check("basic_last", rd_data, 32'd9);
    check("basic_empty", empty, 1'b1);
    $display("phase: basic order done");

    for (int i = 10; i < 20; i++) step(1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0);
    check("burst2_last", rd_data, 32'd19);
    $display("phase: second burst done");

    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, DW'(i));
      if (i == DEPTH - 2) check("not_full_1023", full, 1'b0);
    end
    check("overflow_full", full, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);
    check("drain_last", rd_data, 32'd1023);
    check("drain_empty", empty, 1'b1);
    $display("phase: overflow done");

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);
    check("underflow_rd", rd_data, 32'd1023);
    check("underflow_empty", empty, 1'b1);
    $display("phase: underflow done");

    for (int i = 0; i < 1000; i++) step(1'b1, 1'b0, 32'h1000_0000 + DW'(i));
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 32'h2000_0000 + DW'(i));
      check("wrap_count", dut.count_q, 32'd1000);
    end
    check("wrap_rd", rd_data, 32'h1000_0063);
    $display("phase: wrap with simultaneous traffic done");

    do_reset();
    step(1'b1, 1'b0, 32'hCAFE_0001);
    step(1'b0, 1'b1, '0);
    check("post_reset_rd", rd_data, 32'hCAFE_0001);
    $display("phase: mid-stream reset done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
